exu_cal_arb: RTL and testbench

Two-requester round-robin arbiter and result buffer for the shared combinational calculation unit (add/sub/shift/xor/compare) in the execute stage. It accepts one operation bundle per cycle from either the main ALU issue path (r0) or the branch-compare path (r1), drives it into the calculation unit with a valid/ready handshake, and captures the 32-bit result into a per-requester one-deep response buffer. The buffer is drained through a second valid/ready handshake.

---
 rtl/exu_cal_arb.sv | 66 ++++++
 tb/tb_exu_cal_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_cal_arb.sv
// exu_cal_arb: round-robin arbiter into the shared calc unit with per-requester one-deep result buffers
`ifndef CIRNO_CAL_OPB_SIZE
`define CIRNO_CAL_OPB_SIZE 74
`endif
module exu_cal_arb #(
  parameter int OPB_W = `CIRNO_CAL_OPB_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_r0arb_val,
  input  logic             hs_r1arb_val,
  output logic             hs_arbr0_rdy,
  output logic             hs_arbr1_rdy,
  input  logic [OPB_W-1:0] r0_opb,
  input  logic [OPB_W-1:0] r1_opb,
  output logic             hs_arbr0_rsp_val,
  output logic             hs_arbr1_rsp_val,
  input  logic             hs_r0arb_rsp_rdy,
  input  logic             hs_r1arb_rsp_rdy,
  output logic [31:0]      r0_res,
  output logic [31:0]      r1_res,
  input  logic             flush,
  output logic             hs_ex4cal_val,
  input  logic             hs_cal4ex_rdy,
  output logic [OPB_W-1:0] cal_opb,
  input  logic [31:0]      cal_res
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic lock_k, prio, gnt, gnt_val, hs;
  logic [1:0] val, rsp_rdy, rsp_val, elig;
  logic [1:0][31:0] res;
  assign val = {hs_r1arb_val, hs_r0arb_val};
  assign rsp_rdy = {hs_r1arb_rsp_rdy, hs_r0arb_rsp_rdy};
  assign elig = val & {2{~flush}} & (~rsp_val | rsp_rdy);
  always_comb begin
    gnt_val = ~flush & ((state == LOCK) | (|elig));
    gnt = (state == LOCK) ? lock_k : (&elig) ? prio : elig[1];
  end
  assign hs = gnt_val & hs_cal4ex_rdy;
  assign hs_ex4cal_val = gnt_val;
  assign hs_arbr0_rdy = hs & ~gnt;
  assign hs_arbr1_rdy = hs & gnt;
  assign cal_opb = gnt_val ? (gnt ? r1_opb : r0_opb) : '0;
  assign hs_arbr0_rsp_val = rsp_val[0];
  assign hs_arbr1_rsp_val = rsp_val[1];
  assign r0_res = res[0];
  assign r1_res = res[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lock_k <= 1'b0;
      prio <= 1'b0;
      rsp_val <= '0;
      res <= '0;
    end else begin
      state <= (gnt_val && !hs_cal4ex_rdy) ? LOCK : IDLE;
      lock_k <= gnt;
      rsp_val <= flush ? 2'b00 : (rsp_val & ~rsp_rdy) | ({2{hs}} & {gnt, ~gnt});
      if (hs) begin
        res[gnt] <= cal_res;
        prio <= ~gnt;
      end
    end
  end
endmodule

// File: tb/tb_exu_cal_arb.sv
// tb_exu_cal_arb: directed scenarios plus randomized traffic against a transaction-level model
module tb_exu_cal_arb;
  localparam int W = 74;
  logic clk = 1'b0, rst = 1'b1;
  logic hs_r0arb_val = 0, hs_r1arb_val = 0, hs_arbr0_rdy, hs_arbr1_rdy;
  logic [W-1:0] r0_opb = '0, r1_opb = '0, cal_opb;
  logic hs_arbr0_rsp_val, hs_arbr1_rsp_val;
  logic hs_r0arb_rsp_rdy = 0, hs_r1arb_rsp_rdy = 0;
  logic [31:0] r0_res, r1_res, cal_res;
  logic flush = 0, hs_ex4cal_val, hs_cal4ex_rdy = 0;
  int checks = 0, failures = 0;
  int m_lock;
  logic m_prio;
  logic [1:0] m_rv;
  logic [31:0] m_buf [2];

  exu_cal_arb #(.OPB_W(W)) dut (
    .clk(clk), .rst(rst),
    .hs_r0arb_val(hs_r0arb_val), .hs_r1arb_val(hs_r1arb_val),
    .hs_arbr0_rdy(hs_arbr0_rdy), .hs_arbr1_rdy(hs_arbr1_rdy),
    .r0_opb(r0_opb), .r1_opb(r1_opb),
    .hs_arbr0_rsp_val(hs_arbr0_rsp_val), .hs_arbr1_rsp_val(hs_arbr1_rsp_val),
    .hs_r0arb_rsp_rdy(hs_r0arb_rsp_rdy), .hs_r1arb_rsp_rdy(hs_r1arb_rsp_rdy),
    .r0_res(r0_res), .r1_res(r1_res), .flush(flush),
    .hs_ex4cal_val(hs_ex4cal_val), .hs_cal4ex_rdy(hs_cal4ex_rdy),
    .cal_opb(cal_opb), .cal_res(cal_res)
  );

  always #5 clk = ~clk;

  // Calc unit stand-in: opb = {op[7:0] one-hot, opn1[32:0], opn2[32:0]}
  function automatic logic [31:0] calc(logic [W-1:0] o);
    logic [32:0] a, b;
    a = o[65:33];
    b = o[32:0];
    if (o[66]) return a[31:0] + b[31:0];
    if (o[67]) return a[31:0] - b[31:0];
    if (o[68]) return a[31:0] << b[4:0];
    if (o[69]) return a[31:0] ^ b[31:0];
    if (o[70]) return {31'd0, $signed(a) < $signed(b)};
    return 32'd0;
  endfunction

  assign cal_res = calc(cal_opb);

  function automatic logic [W-1:0] mk(int opi, logic [32:0] a, logic [32:0] b);
    return {8'(1 << opi), a, b};
  endfunction

  function automatic logic [W-1:0] rand_opb();
    return mk(int'($urandom_range(0, 4)), {1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)});
  endfunction

  // Which requester the spec says owns the calc unit this cycle (-1: none)
  function automatic int exp_gnt();
    logic e0, e1;
    if (flush) return -1;
    if (m_lock >= 0) return m_lock;
    e0 = hs_r0arb_val && (!m_rv[0] || hs_r0arb_rsp_rdy);
    e1 = hs_r1arb_val && (!m_rv[1] || hs_r1arb_rsp_rdy);
    if (e0 && e1) return int'(m_prio);
    return e0 ? 0 : e1 ? 1 : -1;
  endfunction

  task automatic model_reset();
    m_lock = -1;
    m_prio = 0;
    m_rv = 2'b00;
    m_buf[0] = 0;
    m_buf[1] = 0;
  endtask

  task automatic model_update();
    int g;
    logic acc;
    logic [1:0] rr;
    g = exp_gnt();
    acc = (g >= 0) && hs_cal4ex_rdy;
    rr = {hs_r1arb_rsp_rdy, hs_r0arb_rsp_rdy};
    for (int k = 0; k < 2; k++) begin
      if (flush) m_rv[k] = 0;
      else if (acc && g == k) begin
        m_rv[k] = 1;
        m_buf[k] = calc(k == 1 ? r1_opb : r0_opb);
      end else if (rr[k]) m_rv[k] = 0;
    end
    if (acc) m_prio = (g == 0);
    m_lock = ((g >= 0) && !hs_cal4ex_rdy) ? g : -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    hs_r0arb_val = 0; hs_r1arb_val = 0;
    hs_r0arb_rsp_rdy = 0; hs_r1arb_rsp_rdy = 0;
    hs_cal4ex_rdy = 0; flush = 0;
    r0_opb = '0; r1_opb = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({hs_arbr0_rsp_val, hs_arbr1_rsp_val, hs_ex4cal_val, hs_arbr0_rdy, hs_arbr1_rdy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {hs_arbr0_rsp_val, hs_arbr1_rsp_val, hs_ex4cal_val, hs_arbr0_rdy, hs_arbr1_rdy});
    end
    checks++;
    if (cal_opb !== '0) begin failures++; $display("FAIL reset_cal_opb got=%h exp=0", cal_opb); end
    checks++;
    if (r0_res !== 32'd0) begin failures++; $display("FAIL reset_r0_res got=%h exp=0", r0_res); end
    checks++;
    if (r1_res !== 32'd0) begin failures++; $display("FAIL reset_r1_res got=%h exp=0", r1_res); end
    tick();
  endtask

  task automatic test_single_add();
    logic [W-1:0] o;
    o = mk(0, 33'd5, 33'd7);
    r0_opb = o; hs_r0arb_val = 1; hs_cal4ex_rdy = 1;
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b01) begin failures++; $display("FAIL add_rdy got=%b exp=01", {hs_arbr1_rdy, hs_arbr0_rdy}); end
    checks++;
    if (cal_opb !== o) begin failures++; $display("FAIL add_cal_opb got=%h exp=%h", cal_opb, o); end
    tick();
    hs_r0arb_val = 0;
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rsp_val, hs_arbr0_rsp_val} !== 2'b01) begin failures++; $display("FAIL add_rsp_val got=%b exp=01", {hs_arbr1_rsp_val, hs_arbr0_rsp_val}); end
    checks++;
    if (r0_res !== 32'd12) begin failures++; $display("FAIL add_r0_res got=%0d exp=12", r0_res); end
    hs_r0arb_rsp_rdy = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    r0_opb = mk(1, 33'd9, 33'd4); r1_opb = mk(2, 33'd1, 33'd3);
    hs_r0arb_val = 1; hs_r1arb_val = 1;
    hs_r0arb_rsp_rdy = 1; hs_r1arb_rsp_rdy = 1; hs_cal4ex_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({hs_arbr1_rdy, hs_arbr0_rdy} !== (i % 2 ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL alt_grant cyc=%0d got=%b exp=%b", i, {hs_arbr1_rdy, hs_arbr0_rdy}, (i % 2 ? 2'b10 : 2'b01));
      end
      if (i > 0) begin
        checks++;
        if ({hs_arbr1_rsp_val, hs_arbr0_rsp_val} !== (i % 2 ? 2'b01 : 2'b10)) begin
          failures++; $display("FAIL alt_rsp_val cyc=%0d got=%b", i, {hs_arbr1_rsp_val, hs_arbr0_rsp_val});
        end
        checks++;
        if ((i % 2 ? r0_res : r1_res) !== (i % 2 ? 32'd5 : 32'd8)) begin
          failures++; $display("FAIL alt_res cyc=%0d got=%0d exp=%0d", i, (i % 2 ? r0_res : r1_res), (i % 2 ? 5 : 8));
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock();
    logic [W-1:0] o1;
    do_reset();
    hs_r0arb_val = 1; r0_opb = mk(0, 33'd1, 33'd1); hs_cal4ex_rdy = 1;
    hs_r0arb_rsp_rdy = 1; hs_r1arb_rsp_rdy = 1;
    tick();
    o1 = mk(3, 33'h0F0F, 33'h00FF);
    hs_r1arb_val = 1; r1_opb = o1; hs_cal4ex_rdy = 0;
    for (int i = 1; i <= 3; i++) begin
      r0_opb = rand_opb();
      @(negedge clk);
      checks++;
      if ({hs_ex4cal_val, hs_arbr1_rdy, hs_arbr0_rdy} !== 3'b100) begin
        failures++; $display("FAIL lock_hold cyc=%0d got=%b exp=100", i, {hs_ex4cal_val, hs_arbr1_rdy, hs_arbr0_rdy});
      end
      checks++;
      if (cal_opb !== o1) begin failures++; $display("FAIL lock_opb cyc=%0d got=%h exp=%h", i, cal_opb, o1); end
      tick();
    end
    hs_cal4ex_rdy = 1;
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b10) begin failures++; $display("FAIL lock_release got=%b exp=10", {hs_arbr1_rdy, hs_arbr0_rdy}); end
    tick();
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b01) begin failures++; $display("FAIL lock_next got=%b exp=01", {hs_arbr1_rdy, hs_arbr0_rdy}); end
    checks++;
    if (r1_res !== 32'h0FF0) begin failures++; $display("FAIL lock_r1_res got=%h exp=00000ff0", r1_res); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] prev;
    do_reset();
    hs_r0arb_val = 1; r0_opb = mk(0, 33'd2, 33'd3); hs_cal4ex_rdy = 1; hs_r1arb_rsp_rdy = 1;
    tick();
    r0_opb = mk(0, 33'd100, 33'd1);
    hs_r1arb_val = 1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      r1_opb = rand_opb();
      @(negedge clk);
      checks++;
      if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b10) begin failures++; $display("FAIL bp_grant cyc=%0d got=%b exp=10", i, {hs_arbr1_rdy, hs_arbr0_rdy}); end
      checks++;
      if (r0_res !== 32'd5 || hs_arbr0_rsp_val !== 1'b1) begin failures++; $display("FAIL bp_r0_hold cyc=%0d got=%0d/%b exp=5/1", i, r0_res, hs_arbr0_rsp_val); end
      if (i > 0) begin
        checks++;
        if (r1_res !== prev) begin failures++; $display("FAIL bp_r1_res cyc=%0d got=%h exp=%h", i, r1_res, prev); end
      end
      prev = calc(r1_opb);
      tick();
    end
    hs_r0arb_rsp_rdy = 1;
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b01) begin failures++; $display("FAIL bp_refill got=%b exp=01", {hs_arbr1_rdy, hs_arbr0_rdy}); end
    checks++;
    if (r1_res !== prev) begin failures++; $display("FAIL bp_r1_last got=%h exp=%h", r1_res, prev); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (hs_arbr0_rsp_val !== 1'b1 || r0_res !== 32'd101) begin failures++; $display("FAIL bp_refill_data got=%b/%0d exp=1/101", hs_arbr0_rsp_val, r0_res); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    hs_r1arb_val = 1; r1_opb = mk(0, 33'd1, 33'd2); hs_cal4ex_rdy = 1;
    tick();
    hs_r1arb_val = 0; hs_r0arb_val = 1; r0_opb = mk(0, 33'd3, 33'd4);
    tick();
    flush = 1; hs_r0arb_rsp_rdy = 1; r0_opb = mk(0, 33'd50, 33'd50);
    @(negedge clk);
    checks++;
    if ({hs_arbr0_rsp_val, hs_arbr1_rsp_val} !== 2'b11) begin failures++; $display("FAIL flush_pre_full got=%b exp=11", {hs_arbr0_rsp_val, hs_arbr1_rsp_val}); end
    checks++;
    if ({hs_ex4cal_val, hs_arbr0_rdy, hs_arbr1_rdy} !== 3'b000) begin failures++; $display("FAIL flush_block got=%b exp=000", {hs_ex4cal_val, hs_arbr0_rdy, hs_arbr1_rdy}); end
    tick();
    flush = 0; hs_r0arb_rsp_rdy = 0; hs_r1arb_val = 1;
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rsp_val, hs_arbr0_rsp_val} !== 2'b00) begin failures++; $display("FAIL flush_clear got=%b exp=00", {hs_arbr1_rsp_val, hs_arbr0_rsp_val}); end
    checks++;
    if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b10) begin failures++; $display("FAIL flush_prio got=%b exp=10", {hs_arbr1_rdy, hs_arbr0_rdy}); end
    checks++;
    if (r0_res !== 32'd7) begin failures++; $display("FAIL flush_data_kept got=%0d exp=7", r0_res); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    hs_r0arb_val = 1; r0_opb = mk(0, 33'd1, 33'd1); hs_cal4ex_rdy = 1;
    tick();
    hs_r0arb_val = 0; hs_r1arb_val = 1; r1_opb = mk(0, 33'd2, 33'd2); hs_cal4ex_rdy = 0;
    tick();
    #2;
    rst = 1;
    hs_r1arb_val = 0;
    #1;
    checks++;
    if ({hs_arbr0_rsp_val, hs_arbr1_rsp_val, hs_ex4cal_val, hs_arbr1_rdy} !== 4'b0000) begin
      failures++; $display("FAIL rst_async got=%b exp=0000", {hs_arbr0_rsp_val, hs_arbr1_rsp_val, hs_ex4cal_val, hs_arbr1_rdy});
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    tick();
    hs_r0arb_val = 1; hs_r1arb_val = 1; r0_opb = mk(0, 33'd20, 33'd22);
    hs_cal4ex_rdy = 1; hs_r0arb_rsp_rdy = 1; hs_r1arb_rsp_rdy = 1;
    @(negedge clk);
    checks++;
    if ({hs_arbr1_rdy, hs_arbr0_rdy} !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%b exp=01", {hs_arbr1_rdy, hs_arbr0_rdy}); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (hs_arbr0_rsp_val !== 1'b1 || r0_res !== 32'd42) begin failures++; $display("FAIL rst_first_res got=%b/%0d exp=1/42", hs_arbr0_rsp_val, r0_res); end
    tick();
  endtask

  task automatic test_random();
    int g;
    logic [W-1:0] eo;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_lock != 0) begin hs_r0arb_val = ($urandom % 4) != 0; r0_opb = rand_opb(); end
      if (m_lock != 1) begin hs_r1arb_val = ($urandom % 4) != 0; r1_opb = rand_opb(); end
      hs_r0arb_rsp_rdy = 1'($urandom);
      hs_r1arb_rsp_rdy = 1'($urandom);
      hs_cal4ex_rdy = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      @(negedge clk);
      g = exp_gnt();
      eo = g == 0 ? r0_opb : g == 1 ? r1_opb : '0;
      checks++;
      if ({hs_ex4cal_val, hs_arbr0_rdy, hs_arbr1_rdy} !== {g >= 0, g == 0 && hs_cal4ex_rdy, g == 1 && hs_cal4ex_rdy}) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp_gnt=%0d cal_rdy=%b", i, {hs_ex4cal_val, hs_arbr0_rdy, hs_arbr1_rdy}, g, hs_cal4ex_rdy);
      end
      checks++;
      if (cal_opb !== eo) begin failures++; $display("FAIL rnd_cal_opb cyc=%0d got=%h exp=%h", i, cal_opb, eo); end
      checks++;
      if ({hs_arbr1_rsp_val, hs_arbr0_rsp_val} !== m_rv) begin failures++; $display("FAIL rnd_rsp_val cyc=%0d got=%b exp=%b", i, {hs_arbr1_rsp_val, hs_arbr0_rsp_val}, m_rv); end
      checks++;
      if (r0_res !== m_buf[0] || r1_res !== m_buf[1]) begin
        failures++; $display("FAIL rnd_res cyc=%0d got=%h/%h exp=%h/%h", i, r0_res, r1_res, m_buf[0], m_buf[1]);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_alternate();
    test_lock();
    test_backpressure();
    test_flush();
    test_reset_mid_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
